// File: rtl/gate_seq_pkg.sv
// Shared encodings and golden truth tables for the gate sequencer.
// Golden tables are consumed only when GATE_SEQ_SELF_CHECK_EN is defined.
package gate_seq_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned TT_W  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_BUF  = 3'd0,
    OP_NOT  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit i is the gate output for vector i ({a,b} = i, or a = i[0] for unary ops).
  localparam logic [TT_W-1:0] TT_BUF  = 4'b0010;
  localparam logic [TT_W-1:0] TT_NOT  = 4'b0001;
  localparam logic [TT_W-1:0] TT_AND  = 4'b1000;
  localparam logic [TT_W-1:0] TT_OR   = 4'b1110;
  localparam logic [TT_W-1:0] TT_NAND = 4'b0111;
  localparam logic [TT_W-1:0] TT_NOR  = 4'b0001;
  localparam logic [TT_W-1:0] TT_XOR  = 4'b0110;
  localparam logic [TT_W-1:0] TT_XNOR = 4'b1001;

  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return op[2:1] == 2'b00;
  endfunction

  // Stimulus {a,b} for a given vector index.
  function automatic logic [1:0] vec_ab(input logic [OP_W-1:0] op,
                                        input logic [IDX_W-1:0] idx);
    return is_unary(op) ? {idx[0], 1'b0} : idx;
  endfunction

endpackage

// File: rtl/gate_seq_ctrl_golden.sv
// Golden truth-table lookup for the selected gate op.
module gate_golden
  import gate_seq_pkg::*;
(
  input  logic [2:0] op,
  output logic [3:0] tt
);

  always_comb begin
    tt = '0;
    case (op)
      OP_BUF:  tt = TT_BUF;
      OP_NOT:  tt = TT_NOT;
      OP_AND:  tt = TT_AND;
      OP_OR:   tt = TT_OR;
      OP_NAND: tt = TT_NAND;
      OP_NOR:  tt = TT_NOR;
      OP_XOR:  tt = TT_XOR;
      OP_XNOR: tt = TT_XNOR;
      default: tt = '0;
    endcase
  end

endmodule

// File: rtl/gate_seq_ctrl.sv
// Sweeps the truth table of an external gate unit and captures its response.
// Define GATE_SEQ_SELF_CHECK_EN to compare the captured table against a golden model.
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] tt,
  output logic       err
);

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a;
  logic             r_b;
  logic [OP_W-1:0]  r_sel;
  logic             r_busy;
  logic             r_done;
  logic [TT_W-1:0]  r_tt;

  logic             w_last;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [1:0]       w_ab_nxt;
  logic [TT_W-1:0]  w_tt_cap;

  assign w_last    = r_idx == (is_unary(r_sel) ? 2'd1 : 2'd3);
  assign w_idx_nxt = w_last ? r_idx : r_idx + 2'd1;
  assign w_ab_nxt  = vec_ab(r_sel, w_idx_nxt);

  always_comb begin
    w_tt_cap        = r_tt;
    w_tt_cap[r_idx] = y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_APPLY;
            r_sel   <= op;
            r_tt    <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_APPLY: begin
          if (r_cnt == CNT_W'(SETTLE - 1)) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          r_tt <= w_tt_cap;
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= ST_APPLY;
            r_idx      <= w_idx_nxt;
            {r_a, r_b} <= w_ab_nxt;
            r_cnt      <= '0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
          r_idx   <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef GATE_SEQ_SELF_CHECK_EN
  logic [TT_W-1:0] w_golden;
  logic            r_err;

  gate_golden u_golden (
    .op (r_sel),
    .tt (w_golden)
  );

  // Judged on the final capture so the bit being written is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_err <= 1'b0;
    end else if (r_state == ST_SAMPLE && w_last && w_tt_cap != w_golden) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign a    = r_a;
  assign b    = r_b;
  assign sel  = r_sel;
  assign busy = r_busy;
  assign done = r_done;
  assign tt   = r_tt;

endmodule
